// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI execute-in-place bridge: register map,
// AXI response codes and the read sequencer state type.
package qspi_pkg;

  localparam logic [31:0] REG_CTRL = 32'h0000_0000;
  localparam logic [31:0] REG_ADDR = 32'h0000_0004;
  localparam logic [31:0] REG_DATA = 32'h0000_0008;
  localparam logic [31:0] REG_STAT = 32'h0000_0028;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ADDR,
    ST_W_CTRL,
    ST_GAP,
    ST_POLL,
    ST_RD_DATA,
    ST_RESP
  } xip_state_t;

endpackage

// File: rtl/xip_word_cache.sv
// Single-entry word cache keyed by flash byte address; invalidate wins over fill.
module xip_word_cache (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        fill,
  input  logic [23:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inv,
  input  logic [23:0] lookup_tag,
  output logic        hit,
  output logic [31:0] data
);

  logic        vld;
  logic [23:0] tag;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld  <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (inv) begin
      vld <= 1'b0;
    end else if (fill) begin
      vld  <= 1'b1;
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

  assign hit = vld && (tag == lookup_tag);

endmodule

// File: rtl/qspi_xip_bridge.sv
// AXI4-Lite XIP read bridge: each flash-window word read becomes an
// ADDR/CTRL write, STAT poll and DATA read on the QSPI master's registers.
//
// state   | meaning
// IDLE    | accept one CPU read; hit goes straight to RESP
// W_ADDR  | write flash address to ADDR register
// W_CTRL  | write 1 to CTRL to start the fetch
// GAP     | one cycle for the QSPI busy flag to assert
// POLL    | read STAT until idle or poll budget spent
// RD_DATA | read DATA register
// RESP    | hold read response until the CPU accepts it
module qspi_xip_bridge
  import qspi_pkg::*;
#(
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter int          POLL_LIMIT   = 1024,
  parameter bit          CACHE_EN     = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic        cache_inv
);

  localparam int PCW = (POLL_LIMIT > 2) ? $clog2(POLL_LIMIT) : 1;

  xip_state_t  state, state_nxt;
  logic [23:0] fa, fa_q;
  logic        aw_done, w_done, ar_done, inv_seen;
  logic [PCW-1:0] poll_cnt;
  logic [31:0] resp_data, resp_data_d, cache_data;
  logic [1:0]  resp_code, resp_code_d;
  logic        load_resp, ar_hs, b_hs, r_hs, hit, cache_hit, fill;
  logic        rvalid_q, bvalid_q, wr_accept;
  logic        unused_ok;

  assign fa    = {s_axi_araddr[23:2], 2'b00} + FLASH_OFFSET;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;
  assign hit   = cache_hit && !cache_inv;
  // An invalidate seen anywhere during the miss keeps the stale word out.
  assign fill  = (state == ST_RD_DATA) && r_hs && (m_axi_rresp == RESP_OKAY)
                 && !inv_seen && !cache_inv;

  generate
    if (CACHE_EN) begin : g_cache
      xip_word_cache u_cache (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .fill       (fill),
        .fill_tag   (fa_q),
        .fill_data  (m_axi_rdata),
        .inv        (cache_inv),
        .lookup_tag (fa),
        .hit        (cache_hit),
        .data       (cache_data)
      );
    end else begin : g_no_cache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_resp   = 1'b0;
    resp_data_d = '0;
    resp_code_d = RESP_OKAY;
    unique case (state)
      ST_IDLE: if (ar_hs) begin
        if (hit) begin
          state_nxt   = ST_RESP;
          load_resp   = 1'b1;
          resp_data_d = cache_data;
        end else begin
          state_nxt = ST_W_ADDR;
        end
      end
      ST_W_ADDR, ST_W_CTRL: if (b_hs) begin
        if (m_axi_bresp != RESP_OKAY) begin
          state_nxt   = ST_RESP;
          load_resp   = 1'b1;
          resp_code_d = RESP_SLVERR;
        end else begin
          state_nxt = (state == ST_W_ADDR) ? ST_W_CTRL : ST_GAP;
        end
      end
      ST_GAP: state_nxt = ST_POLL;
      ST_POLL: if (r_hs) begin
        if (m_axi_rresp != RESP_OKAY || (m_axi_rdata[0] && poll_cnt == '0)) begin
          state_nxt   = ST_RESP;
          load_resp   = 1'b1;
          resp_code_d = RESP_SLVERR;
        end else if (!m_axi_rdata[0]) begin
          state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: if (r_hs) begin
        state_nxt = ST_RESP;
        load_resp = 1'b1;
        if (m_axi_rresp != RESP_OKAY) resp_code_d = RESP_SLVERR;
        else                          resp_data_d = m_axi_rdata;
      end
      ST_RESP: if (s_axi_rvalid && s_axi_rready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (state == ST_IDLE);
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state)
      ST_W_ADDR, ST_W_CTRL: begin
        m_axi_awaddr  = (state == ST_W_ADDR) ? REG_ADDR : REG_CTRL;
        m_axi_wdata   = (state == ST_W_ADDR) ? {8'h00, fa_q} : 32'h1;
        m_axi_wstrb   = 4'hF;
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        m_axi_bready  = 1'b1;
      end
      ST_POLL, ST_RD_DATA: begin
        m_axi_araddr  = (state == ST_POLL) ? REG_STAT : REG_DATA;
        m_axi_arvalid = !ar_done;
        m_axi_rready  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fa_q      <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      inv_seen  <= 1'b0;
      poll_cnt  <= '0;
      resp_data <= '0;
      resp_code <= RESP_OKAY;
      rvalid_q  <= 1'b0;
    end else begin
      if (ar_hs) fa_q <= fa;
      if (state_nxt != state) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
        if (r_hs)                                ar_done <= 1'b0;
        else if (m_axi_arvalid && m_axi_arready) ar_done <= 1'b1;
      end
      // Down-counter: busy result seen at zero is the last permitted poll.
      if (state == ST_GAP)
        poll_cnt <= PCW'(POLL_LIMIT - 1);
      else if (state == ST_POLL && r_hs && m_axi_rdata[0] && poll_cnt != '0)
        poll_cnt <= poll_cnt - PCW'(1);
      if (ar_hs)          inv_seen <= cache_inv;
      else if (cache_inv) inv_seen <= 1'b1;
      if (load_resp) begin
        resp_data <= resp_data_d;
        resp_code <= resp_code_d;
      end
      if (s_axi_rvalid && s_axi_rready) rvalid_q <= 1'b0;
      else if (state == ST_RESP)        rvalid_q <= 1'b1;
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = resp_data;
  assign s_axi_rresp  = resp_code;

  // The flash window is read-only: every write is refused with SLVERR.
  assign wr_accept     = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
  assign s_axi_awready = wr_accept;
  assign s_axi_wready  = wr_accept;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bvalid_q ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                       bvalid_q <= 1'b0;
    else if (wr_accept)                 bvalid_q <= 1'b1;
    else if (bvalid_q && s_axi_bready)  bvalid_q <= 1'b0;
  end

  assign unused_ok = ^{s_axi_araddr[31:24], s_axi_araddr[1:0], s_axi_awaddr,
                       s_axi_wdata, s_axi_wstrb, fill};

endmodule

// File: tb/tb_qspi_xip_bridge.sv
// Bench for qspi_xip_bridge: QSPI register-slave model with transaction log,
// response scoreboard, directed read/write/reset sequence.
module tb_qspi_xip_bridge;
  import qspi_pkg::*;

  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  typedef struct packed {logic [1:0] resp; logic [31:0] data;} rsp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b1;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        cache_inv, inv_man = 1'b0, inv_auto;

  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_rresp   = RESP_OKAY;
  assign cache_inv     = inv_man | inv_auto;

  qspi_xip_bridge #(.FLASH_OFFSET(24'h000000), .POLL_LIMIT(4), .CACHE_EN(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .cache_inv(cache_inv)
  );

  txn_t exp_mq[$], act_mq[$];
  rsp_t exp_rq[$];
  int total = 0, bad = 0;

  // QSPI register-slave model: one-cycle B/R responses, STAT busy for
  // busy_cfg polls after each CTRL write (or forever), DATA returns flash_word.
  int          busy_cfg = 0, busy_left;
  bit          busy_forever = 0, bresp_err = 0, inv_on_poll = 0;
  logic [31:0] flash_word = '0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= '0;
      busy_left    <= 0;
      inv_auto     <= 1'b0;
    end else begin
      inv_auto <= inv_on_poll && m_axi_arvalid && (m_axi_araddr == 32'h28);
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_awvalid && m_axi_wvalid) begin
        act_mq.push_back({1'b1, m_axi_awaddr, m_axi_wdata});
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= bresp_err ? 2'b10 : 2'b00;
        if (m_axi_awaddr == 32'h0) busy_left <= busy_cfg;
      end
      if (m_axi_arvalid) begin
        act_mq.push_back({1'b0, m_axi_araddr, 32'h0});
        m_axi_rvalid <= 1'b1;
        if (m_axi_araddr == 32'h28) begin
          m_axi_rdata <= (busy_forever || busy_left > 0) ? 32'h1 : 32'h0;
          if (busy_left > 0) busy_left <= busy_left - 1;
        end else if (m_axi_araddr == 32'h08) begin
          m_axi_rdata <= flash_word;
        end else begin
          m_axi_rdata <= 32'h0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_miss(input logic [23:0] fa, input int polls, input bit with_data);
    exp_mq.push_back({1'b1, 32'h04, {8'h00, fa}});
    exp_mq.push_back({1'b1, 32'h00, 32'h1});
    repeat (polls) exp_mq.push_back({1'b0, 32'h28, 32'h0});
    if (with_data) exp_mq.push_back({1'b0, 32'h08, 32'h0});
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] edata,
                         input logic [1:0] eresp, input int exp_lat);
    rsp_t r;
    int   cyc, n;
    exp_rq.push_back({eresp, edata});
    @(negedge aclk);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    chk("arready", 65'(s_axi_arready), 65'(1));
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!s_axi_rvalid && cyc < 100);
    chk("rvalid_seen", 65'(s_axi_rvalid), 65'(1));
    r = exp_rq.pop_front();
    chk("rresp", 65'(s_axi_rresp), 65'(r.resp));
    chk("rdata", 65'(s_axi_rdata), 65'(r.data));
    if (exp_lat > 0) chk("latency", 65'(cyc), 65'(exp_lat));
    @(posedge aclk); #1;
    chk("m_log_len", 65'(act_mq.size()), 65'(exp_mq.size()));
    for (int i = 0; i < exp_mq.size() && i < act_mq.size(); i++)
      chk("m_txn", 65'(act_mq[i]), 65'(exp_mq[i]));
    act_mq.delete();
    exp_mq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    chk("rst_arready", 65'(s_axi_arready), 65'(1));
    chk("rst_valids", 65'({s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready,
                           m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 65'(0));
    chk("rst_rdata", 65'({s_axi_rresp, s_axi_rdata}), 65'(0));
    aresetn = 1'b1;

    // Cold miss: 2 busy polls then idle -> 3 polls, 9 + 2*3 cycles to rvalid.
    flash_word = 32'hDEADBEEF; busy_cfg = 2;
    expect_miss(24'h000010, 3, 1'b1);
    do_read(32'h0000_0010, 32'hDEADBEEF, RESP_OKAY, 15);

    // Hit: served from cache even though the flash now holds something else.
    flash_word = 32'h1111_1111; busy_cfg = 0;
    do_read(32'h0000_0010, 32'hDEADBEEF, RESP_OKAY, 2);

    @(negedge aclk); inv_man = 1'b1;
    @(negedge aclk); inv_man = 1'b0;
    expect_miss(24'h000010, 1, 1'b1);
    do_read(32'h0000_0010, 32'h1111_1111, RESP_OKAY, 11);

    // Upper address byte ignored; new tag evicts the old word.
    flash_word = 32'h1234_5678;
    expect_miss(24'h000100, 1, 1'b1);
    do_read(32'hFF00_0100, 32'h1234_5678, RESP_OKAY, 11);
    expect_miss(24'h000010, 1, 1'b1);
    do_read(32'h0000_0010, 32'h1234_5678, RESP_OKAY, 11);

    // Invalidate during an in-flight miss: completes but does not fill.
    inv_on_poll = 1'b1; flash_word = 32'hA5A5_0F0F;
    expect_miss(24'h000030, 1, 1'b1);
    do_read(32'h0000_0030, 32'hA5A5_0F0F, RESP_OKAY, 11);
    inv_on_poll = 1'b0;
    @(negedge aclk);
    expect_miss(24'h000030, 1, 1'b1);
    do_read(32'h0000_0030, 32'hA5A5_0F0F, RESP_OKAY, 11);

    // Status stuck busy: exactly POLL_LIMIT polls then SLVERR, no fill.
    busy_forever = 1'b1;
    expect_miss(24'h000040, 4, 1'b0);
    do_read(32'h0000_0040, 32'h0, RESP_SLVERR, 15);
    busy_forever = 1'b0;
    expect_miss(24'h000040, 1, 1'b1);
    do_read(32'h0000_0040, 32'hA5A5_0F0F, RESP_OKAY, 11);

    // Downstream write error aborts after the first write.
    bresp_err = 1'b1;
    exp_mq.push_back({1'b1, 32'h04, 32'h0000_0020});
    do_read(32'h0000_0020, 32'h0, RESP_SLVERR, 4);
    bresp_err = 1'b0;
    expect_miss(24'h000020, 1, 1'b1);
    do_read(32'h0000_0020, 32'hA5A5_0F0F, RESP_OKAY, 11);

    // Slave write is refused without touching the QSPI master.
    @(negedge aclk);
    s_axi_awaddr = 32'h0; s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge aclk); n++; end
    chk("wr_accept", 65'({s_axi_awready, s_axi_wready}), 65'(2'b11));
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge aclk); n++; end
    chk("bvalid", 65'(s_axi_bvalid), 65'(1));
    chk("bresp", 65'(s_axi_bresp), 65'(RESP_SLVERR));
    @(posedge aclk); #1;
    chk("wr_no_m", 65'(act_mq.size()), 65'(0));

    // Reset while polling.
    busy_cfg = 20;
    @(negedge aclk);
    s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!(m_axi_arvalid && m_axi_araddr == 32'h28) && n < 50) begin @(negedge aclk); n++; end
    chk("reached_poll", 65'(m_axi_arvalid), 65'(1));
    aresetn = 1'b0; #1;
    chk("mid_rst_arready", 65'(s_axi_arready), 65'(1));
    chk("mid_rst_valids", 65'({s_axi_rvalid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                               m_axi_bready, m_axi_rready}), 65'(0));
    chk("mid_rst_addr", 65'({m_axi_awaddr, m_axi_araddr}), 65'(0));
    chk("mid_rst_rdata", 65'({s_axi_rresp, s_axi_rdata}), 65'(0));
    act_mq.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; busy_cfg = 0; flash_word = 32'hCAFE_F00D;
    expect_miss(24'h000004, 1, 1'b1);
    do_read(32'h0000_0004, 32'hCAFE_F00D, RESP_OKAY, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
